// File: rtl/hdmi_timing_pkg.sv
// Shared types and constants for the HDMI/DVI video timing controller:
// FSM encoding, the mode record and the power-on 640x480 timing.
package hdmi_timing_pkg;

    localparam int HDMI_BW = 12;
    localparam int HDMI_BH = 11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        RUN   = ST_RUN,
        DRAIN = ST_DRAIN
    } state_e;

    typedef struct packed {
        logic [HDMI_BW-1:0] fw;
        logic [HDMI_BW-1:0] sw;
        logic [HDMI_BW-1:0] hs;
        logic [HDMI_BW-1:0] hl;
        logic [HDMI_BH-1:0] fh;
        logic [HDMI_BH-1:0] sh;
        logic [HDMI_BH-1:0] vs;
        logic [HDMI_BH-1:0] vl;
        logic               pol;
    } mode_t;

    localparam mode_t MODE_DEFAULT = '{
        fw: 12'd800, sw: 12'd640, hs: 12'd16, hl: 12'd96,
        fh: 11'd525, sh: 11'd480, vs: 11'd10, vl: 11'd2,
        pol: 1'b0
    };

    // A mode needs at least one blank column/row so position (0,0) is never active.
    function automatic logic mode_ok(input mode_t m);
        return (m.fw > m.sw) && (m.fh > m.sh) &&
               (m.fw >= HDMI_BW'(2)) && (m.fh >= HDMI_BH'(2));
    endfunction

endpackage

// File: rtl/hdmi_sync_window.sv
// In-window flag for a sync pulse: start <= cnt < start + len, with the end
// computed one bit wider so a window reaching past the counter range still works.
module hdmi_sync_window #(
    parameter int W = 12
) (
    input  logic [W-1:0] cnt_i,
    input  logic [W-1:0] start_i,
    input  logic [W-1:0] len_i,
    output logic         in_win_o
);

    logic [W:0] end_w;

    assign end_w    = {1'b0, start_i} + {1'b0, len_i};
    assign in_win_o = (cnt_i >= start_i) && ({1'b0, cnt_i} < end_w);

endmodule

// File: rtl/hdmi_timing_ctrl.sv
// Runtime-configurable video timing generator; a new mode is taken from a
// shadow register only at a frame boundary so no frame is ever torn.
module hdmi_timing_ctrl
    import hdmi_timing_pkg::*;
#(
    parameter int BIT_WIDTH  = HDMI_BW,
    parameter int BIT_HEIGHT = HDMI_BH
) (
    input  logic                  pxl_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [BIT_WIDTH-1:0]  cfg_frame_width,
    input  logic [BIT_WIDTH-1:0]  cfg_screen_width,
    input  logic [BIT_WIDTH-1:0]  cfg_hsync_start,
    input  logic [BIT_WIDTH-1:0]  cfg_hsync_len,
    input  logic [BIT_HEIGHT-1:0] cfg_frame_height,
    input  logic [BIT_HEIGHT-1:0] cfg_screen_height,
    input  logic [BIT_HEIGHT-1:0] cfg_vsync_start,
    input  logic [BIT_HEIGHT-1:0] cfg_vsync_len,
    input  logic                  cfg_sync_pol,
    output logic                  cfg_err,
    output logic [BIT_WIDTH-1:0]  cx,
    output logic [BIT_HEIGHT-1:0] cy,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  video_active,
    output logic                  pxl_req,
    output logic                  frame_start,
    output logic                  running,
    output logic [1:0]            state_dbg
);

    localparam logic [BIT_WIDTH-1:0]  ONE_X = {{(BIT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BIT_HEIGHT-1:0] ONE_Y = {{(BIT_HEIGHT-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    mode_t                 live_q, live_d, shad_q, shad_d, cfg_in;
    logic                  pend_q, pend_d;
    logic [BIT_WIDTH-1:0]  cx_q, cx_d, cx_n;
    logic [BIT_HEIGHT-1:0] cy_q, cy_d, cy_n;
    logic                  accept, cfg_good, cx_wrap, cy_wrap, nx_wrap, ny_wrap;
    logic                  active_d, in_h, in_v;
    logic [BIT_WIDTH-1:0]  h_blank;
    logic [BIT_HEIGHT-1:0] v_blank;
    logic                  rdy_q, err_q, hsync_q, vsync_q, va_q, req_q, fs_q, run_q;

    // Config handshake: a transfer happens on a rising edge where cfg_valid and
    // cfg_ready are both 1; cfg_ready is registered and never depends on cfg_valid.
    assign accept   = cfg_valid && rdy_q;
    assign cfg_good = mode_ok(cfg_in);

    always_comb begin
        cfg_in     = MODE_DEFAULT;
        cfg_in.fw  = cfg_frame_width;
        cfg_in.sw  = cfg_screen_width;
        cfg_in.hs  = cfg_hsync_start;
        cfg_in.hl  = cfg_hsync_len;
        cfg_in.fh  = cfg_frame_height;
        cfg_in.sh  = cfg_screen_height;
        cfg_in.vs  = cfg_vsync_start;
        cfg_in.vl  = cfg_vsync_len;
        cfg_in.pol = cfg_sync_pol;
    end

    assign cx_wrap = (cx_q == live_q.fw - ONE_X);
    assign cy_wrap = (cy_q == live_q.fh - ONE_Y);

    always_comb begin
        state_d = state_q;
        live_d  = live_q;
        shad_d  = shad_q;
        pend_d  = pend_q;
        cx_d    = '0;
        cy_d    = '0;
        if (accept && cfg_good) begin
            shad_d = cfg_in;
            pend_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if ((accept && cfg_good) || enable) state_d = LOAD;
            end
            LOAD: begin
                if (pend_q) begin
                    live_d = shad_q;
                    pend_d = 1'b0;
                end
                state_d = enable ? RUN : IDLE;
            end
            RUN, DRAIN: begin
                cx_d = cx_wrap ? '0 : cx_q + ONE_X;
                cy_d = cx_wrap ? (cy_wrap ? '0 : cy_q + ONE_Y) : cy_q;
                if (state_q == RUN) begin
                    if ((accept && cfg_good) || !enable) state_d = DRAIN;
                end else if (cx_wrap && cy_wrap) begin
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Position one step beyond cx_d/cy_d, so pxl_req can lead video_active.
    // Leaving RUN/DRAIN only happens after the last pixel, whose successor (0,0)
    // is always blank, so the plain count successor is sufficient.
    assign nx_wrap = (cx_d == live_d.fw - ONE_X);
    assign ny_wrap = (cy_d == live_d.fh - ONE_Y);
    assign cx_n    = nx_wrap ? '0 : cx_d + ONE_X;
    assign cy_n    = nx_wrap ? (ny_wrap ? '0 : cy_d + ONE_Y) : cy_d;

    assign active_d = (state_d == RUN) || (state_d == DRAIN);
    assign h_blank  = live_d.fw - live_d.sw;
    assign v_blank  = live_d.fh - live_d.sh;

    hdmi_sync_window #(.W(BIT_WIDTH)) u_hwin (
        .cnt_i    (cx_d),
        .start_i  (live_d.hs),
        .len_i    (live_d.hl),
        .in_win_o (in_h)
    );

    hdmi_sync_window #(.W(BIT_HEIGHT)) u_vwin (
        .cnt_i    (cy_d),
        .start_i  (live_d.vs),
        .len_i    (live_d.vl),
        .in_win_o (in_v)
    );

    always_ff @(posedge pxl_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            live_q  <= MODE_DEFAULT;
            shad_q  <= MODE_DEFAULT;
            pend_q  <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            va_q    <= 1'b0;
            req_q   <= 1'b0;
            fs_q    <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= live_d;
            shad_q  <= shad_d;
            pend_q  <= pend_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            rdy_q   <= (state_d == IDLE) || (state_d == RUN);
            err_q   <= accept && !cfg_good;
            hsync_q <= (active_d && in_h) ? live_d.pol : ~live_d.pol;
            vsync_q <= (active_d && in_v) ? live_d.pol : ~live_d.pol;
            va_q    <= active_d && (cx_d >= h_blank) && (cy_d >= v_blank);
            req_q   <= active_d && (cx_n >= h_blank) && (cy_n >= v_blank);
            fs_q    <= active_d && (cx_d == '0) && (cy_d == '0);
            run_q   <= active_d;
        end
    end

    assign cfg_ready    = rdy_q;
    assign cfg_err      = err_q;
    assign cx           = cx_q;
    assign cy           = cy_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign video_active = va_q;
    assign pxl_req      = req_q;
    assign frame_start  = fs_q;
    assign running      = run_q;
    assign state_dbg    = state_q;

endmodule

// File: doc/hdmi_timing_ctrl.md
# hdmi_timing_ctrl

Runtime-configurable video timing controller for the DVI/HDMI output path. It generates the pixel position (cx/cy), sync and active-video qualifiers, and an early pixel request for the upstream pixel source, all in the pixel clock domain. A new video mode can be loaded at any time through a valid/ready config port; the switch takes effect only on a frame boundary, so the TMDS encoders never see a torn frame. It replaces fixed per-VIDEO_ID_CODE timing tables with a sequenced, glitch-free mode switch.

## Interface
- BIT_WIDTH, 12, width of horizontal counters/fields
- BIT_HEIGHT, 11, width of vertical counters/fields
- pxl_clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  level; 1 = generate timing, 0 = stop at next frame end
- cfg_valid / cfg_ready  in / out  1 / 1  config handshake; a transfer happens when both are 1 on a rising edge
- cfg_frame_width, cfg_screen_width, cfg_hsync_start, cfg_hsync_len  in  BIT_WIDTH  horizontal totals and sync window
- cfg_frame_height, cfg_screen_height, cfg_vsync_start, cfg_vsync_len  in  BIT_HEIGHT  vertical totals and sync window
- cfg_sync_pol  in  1  1 = syncs active-high, 0 = active-low
- cfg_err  out  1  one-cycle pulse when a config is rejected
- cx, cy  out  BIT_WIDTH / BIT_HEIGHT  current position
- hsync, vsync  out  1  sync outputs, polarity applied
- video_active  out  1  current pixel is in the screen area
- pxl_req  out  1  the next cycle is video_active; the upstream source reads on this
- frame_start  out  1  pulse at cx=0, cy=0 while running
- running  out  1  state is RUN or DRAIN

## Operation
- Live registers hold the active mode; one shadow register set holds a pending mode.
- Reset values of the live registers (640x480 defaults):
  - frame width/height 800/525, screen width/height 640/480
  - hsync start/length 16/96, vsync start/length 10/2
  - pol 0
- Active area starts after blanking: x ≥ fw−sw and y ≥ fh−sh.
- Sync windows: hsync is asserted for hs ≤ cx < hs+hl, and vsync for vs ≤ cy < vs+vl. Sums are computed one bit wider than the field.
- Config validity: reject if fw ≤ sw, fh ≤ sh, fw < 2 or fh < 2. On reject, pulse cfg_err in the cycle after the handshake, drop the config and leave the state unchanged.
- State machine:
  - **IDLE:**
    - Counters are held at 0, syncs sit at their inactive level, video_active = pxl_req = 0, cfg_ready = 1.
    - If a valid config is accepted, or enable = 1, go to LOAD.
  - **LOAD:** one cycle.
    - If a pending config exists, copy shadow to live and clear pending.
    - Set cx = cy = 0.
    - Go to RUN if enable = 1, else IDLE.
  - **RUN:**
    - Counters advance; cfg_ready = 1.
    - A valid accepted config is stored as pending; go to DRAIN.
    - If enable = 0, go to DRAIN (stop request).
  - **DRAIN:**
    - Counters continue; cfg_ready = 0.
    - At the last pixel (cx = fw−1 and cy = fh−1), go to LOAD.
- Counting: cx wraps at fw−1. cy increments only when cx wraps, and wraps at fh−1.
- Simultaneous cfg accept and enable = 0 in RUN: the config is stored and LOAD leads to IDLE with the new live mode.
- Reset mid-frame: immediately IDLE with defaults; the pending config is discarded.

## Timing
- Async reset values: state IDLE, cx = cy = 0, cfg_ready = 0 during reset (1 from the first cycle after release), cfg_err = 0, hsync = vsync = 1 (inactive for default pol 0), video_active = pxl_req = frame_start = running = 0.
- All outputs are registered. hsync, vsync, video_active and frame_start are aligned to the cx/cy of the same cycle, computed from the next-count value.
- pxl_req leads video_active by exactly 1 cycle, including across line and frame wrap.
- Mode-switch latency: the new mode's cx = cy = 0 appears 2 cycles after the last pixel of the old frame (the LOAD cycle is blank, with syncs inactive).
- Frame period in RUN is exactly fw·fh cycles. Across a switch, one frame is fw·fh+1 cycles.

## Structure
- Package hdmi_timing_pkg holds:
  - the state enum {IDLE, LOAD, RUN, DRAIN}
  - the default 640x480 constants
  - a packed mode-config struct, parameterized by width via localparams
- Sub-module hdmi_sync_window: given counter, start and length, produces the in-window flag using a widened sum. It is instantiated twice (h and v).

## Test plan
- Reset release with enable = 1 → within 1 cycle enter LOAD. Frame is 800×525 = 420000 cycles, hsync low for cx 16..111, first video_active at cx = 160, cy = 45.
- Load 1280×720 (1650/750, hs 110/40, vs 5/5, pol 1) mid-frame → old frame completes, cfg_ready = 0 during DRAIN, new cx = 0 appears 2 cycles after the old last pixel, hsync high for cx 110..149.
- Config with fw = 640, sw = 640 → cfg_err pulses once, timing is unchanged, state stays RUN.
- pxl_req vs video_active over 2 full frames → pxl_req(t) == video_active(t+1) every cycle, including wrap from (799,524) to (0,0).
- enable deasserted at cx = 5, cy = 3 → frame completes, then LOAD, then IDLE. Outputs: cx = cy = 0, syncs inactive, running = 0.
- rst asserted mid-DRAIN with config pending → next frame uses the 640x480 defaults.
